// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the decode/execute datapath.
//   WIDTH              datapath / register width
//   REG_ADDRESS_WIDTH  register index width (32 architectural registers)
//   ZERO_REG           index of the hardwired-zero register
//   CTRL_W             width of the opaque decoded-control bundle
//   CTRL_*             field offsets inside the control bundle. Only EX
//                      interprets them. This stage passes the bundle through.
//   op_sel_e           operand source selected by rf_bypass_mux
package mips_pkg;

  localparam int WIDTH             = 32;
  localparam int REG_ADDRESS_WIDTH = 5;
  localparam int CTRL_W            = 8;

  localparam logic [REG_ADDRESS_WIDTH-1:0] ZERO_REG = 5'd0;

  // Control bundle layout (bit offsets into id_ctrl / ex_ctrl)
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_W   = 4;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_JUMP       = 7;

  typedef enum logic [1:0] {
    OP_SEL_ZERO   = 2'd0,
    OP_SEL_BYPASS = 2'd1,
    OP_SEL_FILE   = 2'd2
  } op_sel_e;

endpackage

// File: rtl/rf_bypass_mux.sv
// rf_bypass_mux: operand source select for one register-file read port.
// The register file is read-first. A read in the same cycle as a writeback
// to the same register would return the stale value, so the writeback data
// is forwarded here.
//   index    in   register index being read
//   rf_rd    in   register-file read data for index
//   wb_we    in   writeback write enable
//   wb_a3    in   writeback write address
//   wb_wd    in   writeback write data
//   operand  out  selected operand (combinational)
module rf_bypass_mux #(
  parameter int WIDTH             = mips_pkg::WIDTH,
  parameter int REG_ADDRESS_WIDTH = mips_pkg::REG_ADDRESS_WIDTH
) (
  input  logic [REG_ADDRESS_WIDTH-1:0] index,
  input  logic [WIDTH-1:0]             rf_rd,
  input  logic                         wb_we,
  input  logic [REG_ADDRESS_WIDTH-1:0] wb_a3,
  input  logic [WIDTH-1:0]             wb_wd,
  output logic [WIDTH-1:0]             operand
);
  import mips_pkg::*;

  op_sel_e sel_s;

  // Source priority: $0 beats the bypass, so a stray write to $0 never leaks.
  // The bypass beats the file.
  always_comb begin
    sel_s = OP_SEL_FILE;
    if (index == {REG_ADDRESS_WIDTH{1'b0}}) begin
      sel_s = OP_SEL_ZERO;
    end else if (wb_we && (wb_a3 == index)) begin
      sel_s = OP_SEL_BYPASS;
    end else begin
      sel_s = OP_SEL_FILE;
    end
  end

  // Drive the operand from the selected source.
  always_comb begin
    operand = {WIDTH{1'b0}};
    case (sel_s)
      OP_SEL_ZERO:   operand = {WIDTH{1'b0}};
      OP_SEL_BYPASS: operand = wb_wd;
      OP_SEL_FILE:   operand = rf_rd;
      default:       operand = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand fetch,
// writeback bypass and load-use hazard handling.
//   clk, rst                  clock, synchronous active-high reset
//   id_*                      decoded instruction currently in ID
//   rf_a1/rf_a2 (out)         register-file read addresses (= id_rs/id_rt)
//   rf_rd1/rf_rd2 (in)        register-file read data
//   wb_we/wb_a3/wb_wd         writeback port, the same nets as the file's write port
//   ex_stall                  EX cannot accept. Hold ID/EX.
//   flush                     kill the instruction in ID
//   stall_id (out)            hold PC and IF/ID this cycle (combinational)
//   ex_* (out)                ID/EX register contents
module id_ex_operand_stage #(
  parameter int WIDTH             = mips_pkg::WIDTH,
  parameter int REG_ADDRESS_WIDTH = mips_pkg::REG_ADDRESS_WIDTH,
  parameter int CTRL_W            = mips_pkg::CTRL_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_ADDRESS_WIDTH-1:0] id_rs,
  input  logic [REG_ADDRESS_WIDTH-1:0] id_rt,
  input  logic                         id_uses_rt,
  input  logic [REG_ADDRESS_WIDTH-1:0] id_dest,
  input  logic                         id_reg_write,
  input  logic                         id_mem_read,
  input  logic [WIDTH-1:0]             id_imm,
  input  logic [WIDTH-1:0]             id_pc,
  input  logic [CTRL_W-1:0]            id_ctrl,
  output logic [REG_ADDRESS_WIDTH-1:0] rf_a1,
  output logic [REG_ADDRESS_WIDTH-1:0] rf_a2,
  input  logic [WIDTH-1:0]             rf_rd1,
  input  logic [WIDTH-1:0]             rf_rd2,
  input  logic                         wb_we,
  input  logic [REG_ADDRESS_WIDTH-1:0] wb_a3,
  input  logic [WIDTH-1:0]             wb_wd,
  input  logic                         ex_stall,
  input  logic                         flush,
  output logic                         stall_id,
  output logic                         ex_valid,
  output logic [WIDTH-1:0]             ex_rs_val,
  output logic [WIDTH-1:0]             ex_rt_val,
  output logic [REG_ADDRESS_WIDTH-1:0] ex_rs,
  output logic [REG_ADDRESS_WIDTH-1:0] ex_rt,
  output logic [REG_ADDRESS_WIDTH-1:0] ex_dest,
  output logic                         ex_reg_write,
  output logic                         ex_mem_read,
  output logic [WIDTH-1:0]             ex_imm,
  output logic [WIDTH-1:0]             ex_pc,
  output logic [CTRL_W-1:0]            ex_ctrl
);
  import mips_pkg::*;

  logic [WIDTH-1:0] rs_val_s;
  logic [WIDTH-1:0] rt_val_s;
  logic             load_use_s;

  assign rf_a1 = id_rs;
  assign rf_a2 = id_rt;

  rf_bypass_mux #(
    .WIDTH             (WIDTH),
    .REG_ADDRESS_WIDTH (REG_ADDRESS_WIDTH)
  ) u_rs_mux (
    .index   (id_rs),
    .rf_rd   (rf_rd1),
    .wb_we   (wb_we),
    .wb_a3   (wb_a3),
    .wb_wd   (wb_wd),
    .operand (rs_val_s)
  );

  rf_bypass_mux #(
    .WIDTH             (WIDTH),
    .REG_ADDRESS_WIDTH (REG_ADDRESS_WIDTH)
  ) u_rt_mux (
    .index   (id_rt),
    .rf_rd   (rf_rd2),
    .wb_we   (wb_we),
    .wb_a3   (wb_a3),
    .wb_wd   (wb_wd),
    .operand (rt_val_s)
  );

  // Load-use hazard: a load in EX targets a register the ID instruction reads.
  // Its data exists only after MEM, so one bubble is needed. A load to $0 is
  // never a hazard. rt counts only when the instruction actually reads it.
  always_comb begin
    load_use_s = 1'b0;
    if (ex_valid && ex_mem_read && (ex_dest != {REG_ADDRESS_WIDTH{1'b0}}) && id_valid) begin
      load_use_s = (ex_dest == id_rs) || (id_uses_rt && (ex_dest == id_rt));
    end else begin
      load_use_s = 1'b0;
    end
  end

  // A flush kills ID outright, so there is nothing to hold even if a
  // hazard is also present.
  assign stall_id = ~rst & ~flush & (ex_stall | load_use_s);

  // ID/EX register: reset > flush bubble > hold > load-use bubble > capture.
  // Bubbles clear only the qualifying bits. The data fields keep stale
  // contents that nobody consumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_rs_val    <= {WIDTH{1'b0}};
      ex_rt_val    <= {WIDTH{1'b0}};
      ex_rs        <= {REG_ADDRESS_WIDTH{1'b0}};
      ex_rt        <= {REG_ADDRESS_WIDTH{1'b0}};
      ex_dest      <= {REG_ADDRESS_WIDTH{1'b0}};
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_imm       <= {WIDTH{1'b0}};
      ex_pc        <= {WIDTH{1'b0}};
      ex_ctrl      <= {CTRL_W{1'b0}};
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (ex_stall) begin
      ex_valid     <= ex_valid;
      ex_reg_write <= ex_reg_write;
      ex_mem_read  <= ex_mem_read;
    end else if (load_use_s) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_rs_val    <= rs_val_s;
      ex_rt_val    <= rt_val_s;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_dest      <= id_dest;
      ex_reg_write <= id_valid & id_reg_write;
      ex_mem_read  <= id_valid & id_mem_read;
      ex_imm       <= id_imm;
      ex_pc        <= id_pc;
      ex_ctrl      <= id_ctrl;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage. It keeps a small architectural model: a
// read-first register file, and the ID/EX entry the pipeline must hold,
// derived from "an operand is the newest value of its register". It also
// has directed vectors with literal expectations.
module tb_id_ex_operand_stage;
  localparam int W = 32;
  localparam int A = 5;
  localparam int C = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, id_valid, id_uses_rt, id_reg_write, id_mem_read;
  logic [A-1:0] id_rs, id_rt, id_dest;
  logic [W-1:0] id_imm, id_pc;
  logic [C-1:0] id_ctrl;
  logic [A-1:0] rf_a1, rf_a2;
  logic [W-1:0] rf_rd1, rf_rd2;
  logic         wb_we;
  logic [A-1:0] wb_a3;
  logic [W-1:0] wb_wd;
  logic         ex_stall, flush, stall_id;
  logic         ex_valid, ex_reg_write, ex_mem_read;
  logic [W-1:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc;
  logic [A-1:0] ex_rs, ex_rt, ex_dest;
  logic [C-1:0] ex_ctrl;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd), .ex_stall(ex_stall), .flush(flush),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl)
  );

  // Register file behaviour: read-first, written by the writeback port on the edge.
  logic [W-1:0] regs [32];
  assign rf_rd1 = regs[rf_a1];
  assign rf_rd2 = regs[rf_a2];

  typedef struct packed {
    logic         valid;
    logic         reg_write;
    logic         mem_read;
    logic         known;     // data fields are meaningful (not after a bubble)
    logic [A-1:0] rs, rt, dest;
    logic [W-1:0] rs_val, rt_val, imm, pc;
    logic [C-1:0] ctrl;
  } entry_t;

  entry_t m;
  entry_t m_nxt;
  logic   chk_en = 1'b0;
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest architectural value of register r, counting this cycle's writeback. $0 is always zero.
  function automatic logic [W-1:0] latest(input logic [A-1:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we && (wb_a3 == r)) return wb_wd;
    return regs[r];
  endfunction

  // The ID instruction needs a value that a load still in EX has not yet fetched.
  function automatic logic waits_on_load();
    return m.valid && m.mem_read && (m.dest != 5'd0) && id_valid &&
           ((m.dest == id_rs) || (id_uses_rt && (m.dest == id_rt)));
  endfunction

  function automatic logic exp_stall();
    return !rst && !flush && (ex_stall || waits_on_load());
  endfunction

  // Model: advance the file and the expected ID/EX entry at each edge.
  always @(posedge clk) begin
    m_nxt = m;
    if (rst) begin
      m_nxt = '0;
      m_nxt.known = 1'b1;
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == 0) ? 32'h0000_1234 : ((i == 5) ? 32'h0 : (32'hA000_0000 | 32'(i)));
    end else begin
      if (flush || (!ex_stall && waits_on_load())) begin
        m_nxt.valid = 1'b0; m_nxt.reg_write = 1'b0; m_nxt.mem_read = 1'b0; m_nxt.known = 1'b0;
      end else if (!ex_stall) begin
        m_nxt.valid     = id_valid;
        m_nxt.reg_write = id_valid && id_reg_write;
        m_nxt.mem_read  = id_valid && id_mem_read;
        m_nxt.known     = 1'b1;
        m_nxt.rs = id_rs; m_nxt.rt = id_rt; m_nxt.dest = id_dest;
        m_nxt.rs_val = latest(id_rs); m_nxt.rt_val = latest(id_rt);
        m_nxt.imm = id_imm; m_nxt.pc = id_pc; m_nxt.ctrl = id_ctrl;
      end
      if (wb_we) regs[wb_a3] <= wb_wd;
    end
    m <= m_nxt;
  end

  // Compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_stall_id", 32'(stall_id), 32'(exp_stall()));
      check("m_ex_valid", 32'(ex_valid), 32'(m.valid));
      check("m_ex_reg_write", 32'(ex_reg_write), 32'(m.reg_write));
      check("m_ex_mem_read", 32'(ex_mem_read), 32'(m.mem_read));
      if (m.known) begin
        check("m_ex_rs_val", ex_rs_val, m.rs_val);
        check("m_ex_rt_val", ex_rt_val, m.rt_val);
        check("m_ex_rs", 32'(ex_rs), 32'(m.rs));
        check("m_ex_rt", 32'(ex_rt), 32'(m.rt));
        check("m_ex_dest", 32'(ex_dest), 32'(m.dest));
        check("m_ex_imm", ex_imm, m.imm);
        check("m_ex_pc", ex_pc, m.pc);
        check("m_ex_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [A-1:0] rs, input logic [A-1:0] rt, input logic urt,
                           input logic [A-1:0] dest, input logic mr, input logic [W-1:0] pc);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_dest = dest;
    id_reg_write = 1'b1; id_mem_read = mr; id_pc = pc;
    id_imm = pc ^ 32'h0000_FF00; id_ctrl = pc[7:0] ^ 8'h5A;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    id_dest = 5'd0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_imm = 32'd0;
    id_pc = 32'd0; id_ctrl = 8'd0; wb_we = 1'b0; wb_a3 = 5'd0; wb_wd = 32'd0;
    ex_stall = 1'b0; flush = 1'b0;

    // Reset for two cycles
    @(posedge clk);
    chk_en = 1'b1;
    step();
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_ex_rs_val", ex_rs_val, 32'd0);
    check("reset_ex_pc", ex_pc, 32'd0);
    check("reset_stall_id", 32'(stall_id), 32'd0);
    rst = 1'b0;

    // Same-cycle writeback to rs=5 while the file still returns 0
    set_instr(5'd5, 5'd6, 1'b1, 5'd7, 1'b0, 32'h100);
    wb_we = 1'b1; wb_a3 = 5'd5; wb_wd = 32'hDEAD_BEEF;
    step();
    check("bypass_rs_val", ex_rs_val, 32'hDEAD_BEEF);
    check("bypass_rt_val", ex_rt_val, 32'hA000_0006);
    wb_we = 1'b0;
    set_instr(5'd5, 5'd6, 1'b1, 5'd7, 1'b0, 32'h104);
    step();
    check("file_after_write", ex_rs_val, 32'hDEAD_BEEF);

    // $0 reads zero despite a nonzero file entry and a write to $0
    set_instr(5'd0, 5'd6, 1'b1, 5'd7, 1'b0, 32'h108);
    wb_we = 1'b1; wb_a3 = 5'd0; wb_wd = 32'h0000_0055;
    step();
    check("zero_reg_rs_val", ex_rs_val, 32'd0);
    wb_we = 1'b0;

    // Load-use: load to $8 then an add reading $8
    set_instr(5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 32'h10C);
    step();
    check("load_captured", 32'(ex_mem_read), 32'd1);
    set_instr(5'd8, 5'd9, 1'b1, 5'd10, 1'b0, 32'h110);
    #1;
    check("load_use_stall", 32'(stall_id), 32'd1);
    step();
    check("load_use_bubble", 32'(ex_valid), 32'd0);
    check("load_use_stall_drops", 32'(stall_id), 32'd0);
    step();
    check("after_bubble_pc", ex_pc, 32'h110);
    check("after_bubble_valid", 32'(ex_valid), 32'd1);

    // False hazard: rt matches but is not read
    set_instr(5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 32'h114);
    step();
    set_instr(5'd3, 5'd8, 1'b0, 5'd11, 1'b0, 32'h118);
    #1;
    check("false_hazard_no_stall", 32'(stall_id), 32'd0);
    step();
    check("false_hazard_pc", ex_pc, 32'h118);

    // Flush over stall
    ex_stall = 1'b1; flush = 1'b1;
    #1;
    check("flush_over_stall_sid", 32'(stall_id), 32'd0);
    step();
    check("flush_bubble", 32'(ex_valid), 32'd0);
    ex_stall = 1'b0; flush = 1'b0;

    // Hold for three cycles; a writeback to $3 lands during the hold
    set_instr(5'd3, 5'd4, 1'b1, 5'd12, 1'b0, 32'h11C);
    step();
    set_instr(5'd3, 5'd4, 1'b1, 5'd13, 1'b0, 32'h120);
    ex_stall = 1'b1; wb_we = 1'b1; wb_a3 = 5'd3; wb_wd = 32'hCAFE_0003;
    for (int i = 0; i < 3; i++) begin
      step();
      wb_we = 1'b0;
      check("hold_pc", ex_pc, 32'h11C);
      check("hold_stall_id", 32'(stall_id), 32'd1);
    end
    ex_stall = 1'b0;
    step();
    check("after_hold_rs_val", ex_rs_val, 32'hCAFE_0003);

    // ex_stall and load-use together: hold first, bubble once the stall drops
    set_instr(5'd2, 5'd0, 1'b0, 5'd9, 1'b1, 32'h124);
    step();
    set_instr(5'd9, 5'd0, 1'b0, 5'd14, 1'b0, 32'h128);
    ex_stall = 1'b1;
    step();
    step();
    check("stall_lu_hold_pc", ex_pc, 32'h124);
    ex_stall = 1'b0;
    #1;
    check("stall_lu_then_stall", 32'(stall_id), 32'd1);
    step();
    check("stall_lu_bubble", 32'(ex_valid), 32'd0);
    step();
    check("stall_lu_capture", ex_pc, 32'h128);

    // Flush together with load-use, then an invalid ID slot
    set_instr(5'd2, 5'd0, 1'b0, 5'd9, 1'b1, 32'h12C);
    step();
    set_instr(5'd9, 5'd0, 1'b0, 5'd15, 1'b0, 32'h130);
    flush = 1'b1;
    #1;
    check("flush_lu_no_stall", 32'(stall_id), 32'd0);
    step();
    flush = 1'b0;
    id_valid = 1'b0; id_mem_read = 1'b1;
    step();
    check("invalid_reg_write", 32'(ex_reg_write), 32'd0);
    check("invalid_mem_read", 32'(ex_mem_read), 32'd0);

    // Reset mid-run clears a valid entry
    set_instr(5'd4, 5'd6, 1'b1, 5'd16, 1'b0, 32'h134);
    step();
    rst = 1'b1;
    step();
    check("midrun_reset_pc", ex_pc, 32'd0);
    rst = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
